pj_unidade_controle: RTL and testbench
======================================

Name: pj_unidade_controle

Overview:
- Moore FSM that sequences the MindFocus game datapath: clears/loads its counters and registers, waits for index generation, times each player response, scores it, and ends after the final round.
- Drives the datapath control inputs (zera*, registra*, conta*) and consumes its status outputs (jogada_feita, botaoIgualMemoria, rodadaIgualFinal) plus the index generator ready.
- Adds a per-round response timeout and a saturating error counter.

Parameters:
- TIMEOUT, 50000, clock cycles allowed in ESPERA before the round counts as missed (>=2).
- TW, 16, width of the internal timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- iniciar  in  1  start request, level-sampled.
- indices_prontos  in  1  index generator ready.
- jogada_feita  in  1  one-cycle button edge pulse from datapath.
- botaoIgualMemoria  in  1  registered button matches current indices.
- rodadaIgualFinal  in  1  round counter equals final round.
- zeraA, zeraRod, zeraR, zeraM, zeraI  out  1 each  datapath clears.
- registraR, registraM  out  1 each  datapath register loads.
- contaA, contaRod, contaI  out  1 each  datapath count enables.
- pronto  out  1  game finished.
- timeout_rodada  out  1  one-cycle pulse when a round times out.
- erros  out  4  wrong answers plus timeouts; saturates at 15.
- db_estado  out  4  current state code.

Behaviour:
- All outputs are Moore, decoded from the state register, except erros and the internal timer, which are registered.
- Reset (reset=0, asynchronous): state=INICIAL; timer=0; erros=0; every output 0; db_estado=0.
- A reset asserted mid-game aborts immediately. No datapath clear is issued until the next PREPARA.
- States, with db_estado code, asserted outputs and transitions:
  - INICIAL (0): nothing asserted. iniciar=1 -> PREPARA.
  - PREPARA (1): zeraA, zeraRod, zeraR, zeraM, zeraI asserted for 1 cycle. Clears erros=0. -> GERA.
  - GERA (2): waits while indices_prontos=0. indices_prontos=1 -> REG_IND.
  - REG_IND (3): registraM, zeraR, zeraI asserted. Clears timer=0. -> ESPERA.
  - ESPERA (4): contaI asserted; timer increments by 1 each cycle.
    - jogada_feita=1 -> REG_JOG (checked first).
    - else timer==TIMEOUT-1 -> TEMPO.
    - else stay.
    - If both conditions hold in the same cycle, jogada_feita wins.
  - REG_JOG (5): registraR asserted. -> COMPARA. The register output is valid in the next cycle.
  - COMPARA (6): contaA asserted iff botaoIgualMemoria=1. If botaoIgualMemoria=0, erros increments. -> PROXIMA.
  - TEMPO (9): timeout_rodada asserted; erros increments. -> PROXIMA.
  - PROXIMA (7): contaRod asserted. -> VERIFICA.
  - VERIFICA (8): rodadaIgualFinal is sampled one cycle after the count, so it reflects the updated round. 1 -> FIM, 0 -> GERA.
  - FIM (15): pronto asserted. iniciar=1 -> PREPARA.
- Unused state codes go to INICIAL on the next clock.
- iniciar is ignored in every state except INICIAL and FIM.
- jogada_feita is ignored outside ESPERA.
- Error counter: 4-bit, held at 15 when already 15.
- Timer: TW bits, counts only in ESPERA, cleared in REG_IND. It never wraps because TEMPO is taken at TIMEOUT-1.
- Latency:
  - Press (jogada_feita) to contaA: 2 cycles (REG_JOG, COMPARA).
  - contaRod to VERIFICA: 1 cycle.
- Timeout: exactly TIMEOUT cycles spent in ESPERA.

Test Plan:
- Reset and start: reset=0 for 3 cycles; all outputs 0, db_estado=0. Release, pulse iniciar -> PREPARA (1) with all five zera* high for exactly 1 cycle, then GERA (2).
- Correct round: in GERA drive indices_prontos=1 -> REG_IND with registraM=1. In ESPERA pulse jogada_feita after 5 cycles -> registraR next cycle. With botaoIgualMemoria=1 -> contaA=1 for 1 cycle, contaRod=1 next cycle, erros stays 0.
- Timeout (TIMEOUT=8): enter ESPERA, no press -> after exactly 8 ESPERA cycles, TEMPO with timeout_rodada=1 for 1 cycle, erros=1, then PROXIMA.
- Tie: TIMEOUT=8, jogada_feita on the 8th ESPERA cycle -> REG_JOG, no timeout_rodada pulse.
- Full game: 3 rounds (correct, wrong, correct); rodadaIgualFinal=1 after the third contaRod -> FIM, pronto=1, erros=1. Pulse iniciar -> PREPARA, erros=0.
- Abort: assert reset=0 while in ESPERA -> state and outputs 0 asynchronously, before the next clock edge. A later iniciar restarts cleanly.

Source files
------------

// File: rtl/pj_unidade_controle.sv
// Control unit for the MindFocus game: sequences the datapath through each round,
// times player responses and keeps a saturating error count.
module pj_unidade_controle #(
    parameter int TIMEOUT = 50000,
    parameter int TW      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       indices_prontos,
    input  logic       jogada_feita,
    input  logic       botaoIgualMemoria,
    input  logic       rodadaIgualFinal,
    output logic       zeraA,
    output logic       zeraRod,
    output logic       zeraR,
    output logic       zeraM,
    output logic       zeraI,
    output logic       registraR,
    output logic       registraM,
    output logic       contaA,
    output logic       contaRod,
    output logic       contaI,
    output logic       pronto,
    output logic       timeout_rodada,
    output logic [3:0] erros,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        GERA     = 4'd2,
        REG_IND  = 4'd3,
        ESPERA   = 4'd4,
        REG_JOG  = 4'd5,
        COMPARA  = 4'd6,
        PROXIMA  = 4'd7,
        VERIFICA = 4'd8,
        TEMPO    = 4'd9,
        FIM      = 4'd15
    } estado_t;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    estado_t       r_estado;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_erros;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
            r_timer  <= '0;
            r_erros  <= '0;
        end else begin
            case (r_estado)
                INICIAL:  if (iniciar) r_estado <= PREPARA;
                PREPARA: begin
                    r_erros  <= '0;
                    r_estado <= GERA;
                end
                GERA:     if (indices_prontos) r_estado <= REG_IND;
                REG_IND: begin
                    r_timer  <= '0;
                    r_estado <= ESPERA;
                end
                ESPERA: begin
                    r_timer <= r_timer + TW'(1);
                    // A press in the last allowed cycle still counts as a response.
                    if (jogada_feita)              r_estado <= REG_JOG;
                    else if (r_timer == TIMER_LAST) r_estado <= TEMPO;
                end
                REG_JOG:  r_estado <= COMPARA;
                COMPARA: begin
                    if (!botaoIgualMemoria) r_erros <= sat_inc(r_erros);
                    r_estado <= PROXIMA;
                end
                TEMPO: begin
                    r_erros  <= sat_inc(r_erros);
                    r_estado <= PROXIMA;
                end
                PROXIMA:  r_estado <= VERIFICA;
                VERIFICA: r_estado <= rodadaIgualFinal ? FIM : GERA;
                FIM:      if (iniciar) r_estado <= PREPARA;
                default:  r_estado <= INICIAL;
            endcase
        end
    end

    always_comb begin
        zeraA          = 1'b0;
        zeraRod        = 1'b0;
        zeraR          = 1'b0;
        zeraM          = 1'b0;
        zeraI          = 1'b0;
        registraR      = 1'b0;
        registraM      = 1'b0;
        contaA         = 1'b0;
        contaRod       = 1'b0;
        contaI         = 1'b0;
        pronto         = 1'b0;
        timeout_rodada = 1'b0;
        case (r_estado)
            PREPARA: begin
                zeraA   = 1'b1;
                zeraRod = 1'b1;
                zeraR   = 1'b1;
                zeraM   = 1'b1;
                zeraI   = 1'b1;
            end
            REG_IND: begin
                registraM = 1'b1;
                zeraR     = 1'b1;
                zeraI     = 1'b1;
            end
            ESPERA:  contaI         = 1'b1;
            REG_JOG: registraR      = 1'b1;
            COMPARA: contaA         = botaoIgualMemoria;
            TEMPO:   timeout_rodada = 1'b1;
            PROXIMA: contaRod       = 1'b1;
            FIM:     pronto         = 1'b1;
            default: ;
        endcase
    end

    assign erros     = r_erros;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_pj_unidade_controle.sv
// Bench for pj_unidade_controle: plays directed and random games against a
// round-level model of expected state codes, outputs and error count.
module tb_pj_unidade_controle;

    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0, indices_prontos = 1'b0, jogada_feita = 1'b0;
    logic botaoIgualMemoria = 1'b0, rodadaIgualFinal = 1'b0;
    logic zeraA, zeraRod, zeraR, zeraM, zeraI, registraR, registraM;
    logic contaA, contaRod, contaI, pronto, timeout_rodada;
    logic [3:0] erros, db_estado;
    logic [11:0] outs;

    int n_checks = 0;
    int n_errors = 0;
    int erros_exp = 0;
    int rounds = 0;
    int final_round = 0;
    int kq[$];
    int pq[$];

    pj_unidade_controle #(.TIMEOUT(TO), .TW(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .indices_prontos(indices_prontos), .jogada_feita(jogada_feita),
        .botaoIgualMemoria(botaoIgualMemoria), .rodadaIgualFinal(rodadaIgualFinal),
        .zeraA(zeraA), .zeraRod(zeraRod), .zeraR(zeraR), .zeraM(zeraM), .zeraI(zeraI),
        .registraR(registraR), .registraM(registraM), .contaA(contaA),
        .contaRod(contaRod), .contaI(contaI), .pronto(pronto),
        .timeout_rodada(timeout_rodada), .erros(erros), .db_estado(db_estado)
    );

    assign outs = {zeraA, zeraRod, zeraR, zeraM, zeraI, registraR, registraM,
                   contaA, contaRod, contaI, pronto, timeout_rodada};

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output set per state code, in the bit order of 'outs'.
    function automatic logic [11:0] exp_outs(input int code, input bit m);
        case (code)
            1:       return 12'hF80;
            3:       return 12'h2A0;
            4:       return 12'h004;
            5:       return 12'h040;
            6:       return m ? 12'h010 : 12'h000;
            7:       return 12'h008;
            9:       return 12'h001;
            15:      return 12'h002;
            default: return 12'h000;
        endcase
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    task automatic expect_state(input string tag, input int code, input bit m);
        check_eq({tag, "_estado"}, 32'(db_estado), 32'(code));
        check_eq({tag, "_outs"}, 32'(outs), 32'(exp_outs(code, m)));
    endtask

    function automatic int sat_add(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    // Called at a negedge while in INICIAL or FIM; leaves the bench in GERA.
    task automatic start_game(input int n);
        iniciar = 1'b1;
        step();
        expect_state("prepara", 1, 1'b0);
        iniciar = 1'b0;
        step();
        erros_exp   = 0;
        rounds      = 0;
        final_round = n;
        expect_state("gera_start", 2, 1'b0);
        check_eq("erros_cleared", 32'(erros), 32'(erros_exp));
    endtask

    // kind: 0 correct press, 1 wrong press, 2 no press; press = ESPERA cycle of the press.
    task automatic play_round(input int kind, input int press);
        int  g;
        bit  pressed;
        g = $urandom_range(0, 3);
        for (int i = 0; i < g; i++) begin
            expect_state("gera", 2, 1'b0);
            jogada_feita = 1'($urandom_range(0, 1));
            iniciar      = 1'($urandom_range(0, 1));
            step();
        end
        expect_state("gera", 2, 1'b0);
        indices_prontos = 1'b1;
        jogada_feita    = 1'b0;
        iniciar         = 1'b0;
        step();
        expect_state("reg_ind", 3, 1'b0);
        indices_prontos = 1'b0;
        step();
        pressed = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            expect_state("espera", 4, 1'b0);
            if (kind != 2 && c == press) begin
                jogada_feita      = 1'b1;
                botaoIgualMemoria = (kind == 0);
                iniciar           = 1'b0;
                pressed           = 1'b1;
                step();
                jogada_feita = 1'b0;
                break;
            end
            botaoIgualMemoria = 1'($urandom_range(0, 1));
            iniciar           = 1'($urandom_range(0, 1));
            step();
        end
        iniciar = 1'b0;
        if (pressed) begin
            expect_state("reg_jog", 5, 1'b0);
            step();
            expect_state("compara", 6, kind == 0);
            if (kind == 1) erros_exp = sat_add(erros_exp);
            step();
        end else begin
            expect_state("tempo", 9, 1'b0);
            erros_exp = sat_add(erros_exp);
            step();
        end
        expect_state("proxima", 7, 1'b0);
        check_eq("erros", 32'(erros), 32'(erros_exp));
        rounds++;
        rodadaIgualFinal = (rounds == final_round);
        step();
        expect_state("verifica", 8, 1'b0);
        step();
        rodadaIgualFinal = 1'b0;
        if (rounds == final_round) begin
            expect_state("fim", 15, 1'b0);
            check_eq("erros_final", 32'(erros), 32'(erros_exp));
        end
    endtask

    task automatic play_queued();
        while (kq.size() > 0) play_round(kq.pop_front(), pq.pop_front());
    endtask

    initial begin
        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state("reset", 0, 1'b0);
            check_eq("reset_erros", 32'(erros), 32'd0);
        end
        reset = 1'b1;
        step();
        expect_state("inicial", 0, 1'b0);

        // Directed game: correct, wrong, correct
        start_game(3);
        kq = '{0, 1, 0};
        pq = '{5, 3, 1};
        play_queued();
        iniciar = 1'b0;
        jogada_feita = 1'b1;
        step();
        jogada_feita = 1'b0;
        expect_state("fim_hold", 15, 1'b0);

        // Timeout round followed by a press on the last allowed cycle
        start_game(2);
        kq = '{2, 0};
        pq = '{0, TO};
        play_queued();

        // Saturation: 17 misses of random flavour
        start_game(17);
        for (int r = 0; r < 17; r++) begin
            kq.push_back($urandom_range(1, 2));
            pq.push_back($urandom_range(1, TO));
        end
        play_queued();
        check_eq("erros_saturated", 32'(erros), 32'd15);

        // Random games
        for (int gme = 0; gme < 3; gme++) begin
            int n;
            n = $urandom_range(2, 6);
            start_game(n);
            for (int r = 0; r < n; r++) begin
                kq.push_back($urandom_range(0, 2));
                pq.push_back($urandom_range(1, TO));
            end
            play_queued();
        end

        // Abort from ESPERA
        start_game(4);
        indices_prontos = 1'b1;
        step();
        indices_prontos = 1'b0;
        step();
        step();
        expect_state("abort_pre", 4, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        expect_state("abort", 0, 1'b0);
        check_eq("abort_erros", 32'(erros), 32'd0);
        step();
        reset = 1'b1;
        step();
        expect_state("after_abort", 0, 1'b0);
        start_game(1);
        play_round(0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
